// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin owner arbiter for the shared 4:1 mux datapath
//
// Grants the shared 4:1 mux to one of four requesters at a time. Each
// requester holds its request for as long as it uses the mux. Owners are
// chosen in rotating order, starting at the requester after the last owner.
//
// Optional feature macro: ARB_HOLD_LIMIT_EN
//   When defined, an owner that has held the grant for MAX_HOLD cycles is
//   preempted if another request is pending. When undefined, the hold
//   counter is absent and the owner keeps the grant until it drops req.
//
// Ports:
//   clk    in   system clock; all state changes on the rising edge
//   rst    in   synchronous active-high reset
//   req    in   [3:0] request per requester (bit i = mux input i)
//   grant  out  [3:0] registered one-hot grant, zero when there is no owner
//   sel    out  [1:0] registered mux select, index of current or last owner
//   busy   out  high while any grant bit is set

module rr_mux_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       busy
);

    if ((MAX_HOLD < 2) || (MAX_HOLD > 15) || ((1 << CNT_W) <= MAX_HOLD)) begin : g_bad_hold_cfg
        $error("rr_mux_arbiter: MAX_HOLD must be 2..15 and fit in CNT_W bits");
    end

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] sel_q,   sel_d;
    logic [1:0] last_q,  last_d;
    logic [1:0] win;

    // First set bit of mask, scanning ptr+1, ptr+2, ptr+3, ptr (wrapping).
    function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic [3:0] mask);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = ptr;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && mask[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

`ifdef ARB_HOLD_LIMIT_EN
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             others_pending;
    assign others_pending = |(req & ~grant_q);
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        last_d  = last_q;
        win     = 2'd0;
`ifdef ARB_HOLD_LIMIT_EN
        hold_cnt_d = hold_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    win     = rr_pick(last_q, req);
                    grant_d = 4'b0001 << win;
                    sel_d   = win;
                    last_d  = win;
                    state_d = GRANT;
`ifdef ARB_HOLD_LIMIT_EN
                    hold_cnt_d = '0;
`endif
                end
            end
            GRANT: begin
                // In GRANT, sel_q always names the current owner.
                if (req[sel_q]) begin
`ifdef ARB_HOLD_LIMIT_EN
                    if ((hold_cnt_q == CNT_W'(MAX_HOLD - 1)) && others_pending) begin
                        win        = rr_pick(sel_q, req & ~grant_q);
                        grant_d    = 4'b0001 << win;
                        sel_d      = win;
                        last_d     = win;
                        hold_cnt_d = '0;
                    end else if (hold_cnt_q != CNT_W'(MAX_HOLD - 1)) begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
`endif
                end else if (|req) begin
                    // Owner released with others waiting: hand over on this edge.
                    win     = rr_pick(sel_q, req);
                    grant_d = 4'b0001 << win;
                    sel_d   = win;
                    last_d  = win;
`ifdef ARB_HOLD_LIMIT_EN
                    hold_cnt_d = '0;
`endif
                end else begin
                    grant_d = 4'b0000;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 4'b0000;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt_q <= hold_cnt_d;
`endif
        end
    end

    assign grant = grant_q;
    assign sel   = sel_q;
    assign busy  = |grant_q;

endmodule
